// File: rtl/adder_pkg.sv
// adder_pkg: shared types and width helper for the N-channel streaming adder.
//   out_w()  - result/accumulator width from channel width, channel count, guard bits
//   mode_t   - per-transfer operating mode
//   res_t    - {ovf, data} result payload at the default configuration
package adder_pkg;

   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned CH_N_DEF    = 4;
   localparam int unsigned ACC_EXT_DEF = 8;

   // Sum of CH_N unsigned DATA_W values needs clog2(CH_N) carry bits; ACC_EXT adds headroom.
   function automatic int unsigned out_w(input int unsigned data_w,
                                         input int unsigned ch_n,
                                         input int unsigned acc_ext);
      return data_w + 32'($clog2(ch_n)) + acc_ext;
   endfunction

   localparam int unsigned OUT_W_DEF = out_w(DATA_W_DEF, CH_N_DEF, ACC_EXT_DEF);

   typedef enum logic {
      MODE_SUM = 1'b0,
      MODE_ACC = 1'b1
   } mode_t;

   typedef struct packed {
      logic                 ovf;
      logic [OUT_W_DEF-1:0] data;
   } res_t;

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: generic 2-entry registered FIFO with a registered head output.
//   clk, rst      - clock, synchronous active-high reset
//   push/din/full - write side; push is ignored while full
//   pop/dout/valid- read side; dout is the head entry, valid when non-empty
module stream_fifo2 #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         full,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         valid
);

   logic [W-1:0] head_q;
   logic [W-1:0] tail_q;
   logic [1:0]   count_q;
   logic         do_push;
   logic         do_pop;

   assign full    = (count_q == 2'd2);
   assign valid   = (count_q != 2'd0);
   assign dout    = head_q;
   assign do_push = push && !full;
   assign do_pop  = pop && valid;

   // Head slot always holds the oldest entry, so dout comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b11: begin
               // Pushed entry lands behind the one being popped.
               if (count_q == 2'd1) begin
                  head_q <= din;
               end else begin
                  head_q <= tail_q;
                  tail_q <= din;
               end
            end
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_q <= din;
               end else begin
                  tail_q <= din;
               end
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/adder_join_n.sv
// adder_join_n: joins CH_N valid/ready input streams and emits their sum, either
// plain or accumulated with a wrap flag, through a 2-entry elastic output buffer.
//   clk, rst            - clock, synchronous active-high reset
//   in_data/in_valid    - CH_N unsigned channels, channel i at [i*DATA_W +: DATA_W]
//   in_ready            - common ready for all channels (all consumed together)
//   mode                - 0 = sum, 1 = accumulate; sampled on each transfer
//   acc_clr             - clears the accumulator (treated as 0 on a same-cycle transfer)
//   out_data/out_ovf    - result and accumulator-wrap flag
//   out_valid/out_ready - output handshake
module adder_join_n
   import adder_pkg::*;
#(
   parameter  int unsigned DATA_W  = 16,
   parameter  int unsigned CH_N    = 4,
   parameter  int unsigned ACC_EXT = 8,
   localparam int unsigned OUT_W   = out_w(DATA_W, CH_N, ACC_EXT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CH_N*DATA_W-1:0] in_data,
   input  logic [CH_N-1:0]        in_valid,
   output logic [CH_N-1:0]        in_ready,
   input  logic                   mode,
   input  logic                   acc_clr,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_ovf,
   output logic                   out_valid,
   input  logic                   out_ready
);

   typedef struct packed {
      logic             ovf;
      logic [OUT_W-1:0] data;
   } res_w_t;

   localparam int unsigned RES_W = $bits(res_w_t);

   logic             all_v;
   logic             full;
   logic             fire;
   mode_t            mode_e;
   logic [OUT_W-1:0] sum;
   logic [OUT_W-1:0] acc_q;
   logic [OUT_W-1:0] acc_base;
   logic [OUT_W:0]   acc_sum;
   logic [OUT_W-1:0] acc_nxt;
   res_w_t           res;
   res_w_t           head;

   // Join: only a complete set of channels transfers; full is registered, so
   // ready never depends combinationally on out_ready. Held off during reset
   // so nothing is acknowledged in a cycle whose state is being discarded.
   assign all_v    = &in_valid;
   assign fire     = all_v && !full && !rst;
   assign in_ready = {CH_N{fire}};
   assign mode_e   = mode_t'(mode);

   // Zero-extended channel sum at OUT_W; wide enough that it cannot overflow.
   always_comb begin
      sum = '0;
      for (int i = 0; i < int'(CH_N); i++) begin
         sum = sum + OUT_W'(in_data[i*int'(DATA_W) +: DATA_W]);
      end
   end

   // Accumulate path; bit OUT_W of acc_sum is the wrap indication.
   assign acc_base = acc_clr ? '0 : acc_q;
   assign acc_sum  = {1'b0, acc_base} + {1'b0, sum};

   // Result payload for the output buffer.
   always_comb begin
      res.ovf  = 1'b0;
      res.data = sum;
      if (mode_e == MODE_ACC) begin
         res.ovf  = acc_sum[OUT_W];
         res.data = acc_sum[OUT_W-1:0];
      end
   end

   // Next accumulator: sum-mode transfers leave it alone except for a clear.
   always_comb begin
      acc_nxt = acc_q;
      if (fire && (mode_e == MODE_ACC)) begin
         acc_nxt = acc_sum[OUT_W-1:0];
      end else if (acc_clr) begin
         acc_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_nxt;
      end
   end

   // Elastic output stage; out_* come directly from its head register.
   stream_fifo2 #(
      .W (RES_W)
   ) u_out_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (fire),
      .din   (res),
      .full  (full),
      .pop   (out_ready),
      .dout  (head),
      .valid (out_valid)
   );

   assign out_data = head.data;
   assign out_ovf  = head.ovf;

endmodule
